// File: rtl/prg_injector.sv
// ---------------------------------------------------------------------------
// prg_injector
//
// Loads a Commodore PRG file, streamed one byte at a time, into PET RAM
// through a DMA write port. The first two file bytes give the little-endian
// load address. Every following byte is written to consecutive RAM
// addresses.
//
// When the file ends, the block can optionally update the BASIC 4
// end-of-program pointers. VARTAB, ARYTAB and STREND (in zero page at
// PTR_BASE, +2 and +4) are all set to the first free address after the
// loaded image.
//
// Writes into the ROM/IO area (address >= 16'h8000) are never issued. Such
// bytes are dropped and flagged as an error.
//
// Parameters
//   PTR_BASE    zero-page address of VARTAB (ARYTAB/STREND follow at +2/+4)
//   PTR_UPDATE  1 = write the end pointers after a load, 0 = skip them
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   dl_start   one-cycle pulse: a new download begins (valid in any state)
//   dl_valid   dl_data holds a file byte (taken when dl_valid & dl_ready)
//   dl_data    file byte
//   dl_end     one-cycle pulse: the download is complete
//   dl_ready   block accepts a byte this cycle
//   dma_addr   RAM write address (bit 15 is never set while dma_we=1)
//   dma_din    RAM write data
//   dma_we     one-cycle write strobe
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse on an error-free completion
//   error      sticky error of the last load, cleared by dl_start
// ---------------------------------------------------------------------------
module prg_injector #(
  parameter logic [7:0] PTR_BASE   = 8'h2A,
  parameter int         PTR_UPDATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_start,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  input  logic        dl_end,
  output logic        dl_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    DATA    = 3'd3,
    PTR     = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // First address of the ROM/IO area. It is also the saturation value of
  // the write counter.
  localparam logic [15:0] ROM_BASE     = 16'h8000;
  localparam logic [2:0]  PTR_LAST_IDX = 3'd5;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;             // next RAM address to write
  logic [7:0]  addr_lo_q, addr_lo_d;     // load address low byte
  logic        rom_load_q, rom_load_d;   // load address >= ROM_BASE
  logic [2:0]  ptr_idx_q, ptr_idx_d;     // pointer byte being written (0..5)
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        dl_ready_q, dl_ready_d;
  logic        dma_we_q, dma_we_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;

  logic        accept;
  logic [7:0]  ptr_addr;

  // dl_ready_q always matches the current state, because it is registered
  // from the next state. A byte is therefore taken exactly when the state
  // can use it.
  assign accept   = dl_valid & dl_ready_q;
  assign ptr_addr = PTR_BASE + {5'd0, ptr_idx_q};

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so
    // no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_lo_d  = addr_lo_q;
    rom_load_d = rom_load_q;
    ptr_idx_d  = ptr_idx_q;
    error_d    = error_q;
    dma_we_d   = 1'b0;
    dma_addr_d = dma_addr_q;
    dma_din_d  = dma_din_q;

    if (dl_start) begin
      // Restart from any state. A byte offered in the same cycle is
      // ignored, and any pointer writes still pending are abandoned.
      state_d   = ADDR_LO;
      error_d   = 1'b0;
      ptr_idx_d = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: ;

        ADDR_LO: begin
          if (dl_end) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else if (accept) begin
            addr_lo_d = dl_data;
            state_d   = ADDR_HI;
          end
        end

        ADDR_HI: begin
          if (dl_end) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else if (accept) begin
            cnt_d      = {dl_data, addr_lo_q};
            rom_load_d = dl_data[7];
            state_d    = DATA;
          end
        end

        DATA: begin
          // A byte that arrives together with dl_end is still written. Its
          // write registers before the first pointer write.
          if (accept) begin
            if (!cnt_q[15]) begin
              dma_we_d   = 1'b1;
              dma_addr_d = cnt_q;
              dma_din_d  = dl_data;
              cnt_d      = cnt_q + 16'd1;
            end else begin
              error_d = 1'b1;
              cnt_d   = ROM_BASE;
            end
          end
          if (dl_end) begin
            ptr_idx_d = 3'd0;
            state_d   = ((PTR_UPDATE != 0) && !rom_load_q) ? PTR : FINISH;
          end
        end

        PTR: begin
          // Even offsets take the low byte of the end address and odd
          // offsets take the high byte. This fills VARTAB, ARYTAB and
          // STREND in turn.
          dma_we_d   = 1'b1;
          dma_addr_d = {8'h00, ptr_addr};
          dma_din_d  = ptr_idx_q[0] ? cnt_q[15:8] : cnt_q[7:0];
          if (ptr_idx_q == PTR_LAST_IDX) begin
            state_d = FINISH;
          end else begin
            ptr_idx_d = ptr_idx_q + 3'd1;
          end
        end

        FINISH: state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered from the next state. done is high for
    // the single cycle spent in FINISH.
    done_d     = (state_d == FINISH) && !error_d;
    busy_d     = (state_d != IDLE);
    dl_ready_d = (state_d == ADDR_LO) || (state_d == ADDR_HI) ||
                 (state_d == DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'h0000;
      addr_lo_q  <= 8'h00;
      rom_load_q <= 1'b0;
      ptr_idx_q  <= 3'd0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dl_ready_q <= 1'b0;
      dma_we_q   <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_din_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments. Every flop samples the pre-edge
      // value of every other flop, whatever order the lines are in.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_lo_q  <= addr_lo_d;
      rom_load_q <= rom_load_d;
      ptr_idx_q  <= ptr_idx_d;
      error_q    <= error_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dl_ready_q <= dl_ready_d;
      dma_we_q   <= dma_we_d;
      dma_addr_q <= dma_addr_d;
      dma_din_q  <= dma_din_d;
    end
  end

  assign dl_ready = dl_ready_q;
  assign dma_addr = dma_addr_q;
  assign dma_din  = dma_din_q;
  assign dma_we   = dma_we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
